// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage of the 5-stage RISCV core.
// The PC select enum is shared with ID/EX, which drives the redirect.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        NEXTPC     = 2'd0,
        ALU_RESULT = 2'd1,
        NOP_PC_MUX = 2'd2
    } pc_mux;

    localparam logic [31:0] OPCODE_NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instr, pc} entries between the memory port and ID.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_q;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one word request at a time, buffers responses in a
// prefetch FIFO and hands one instruction per cycle to ID, honouring stall and flush/redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = OPCODE_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        flush_en_ip,
    input  pc_mux       pc_mux_ip,
    input  logic [31:0] branch_target_ip,
    output logic        imem_req_op,
    output logic [31:0] imem_addr_op,
    input  logic        imem_gnt_ip,
    input  logic        imem_rvalid_ip,
    input  logic [31:0] imem_rdata_ip,
    output logic        instr_data_valid_op,
    output logic [31:0] instr_data_op,
    output logic [31:0] pc_op,
    output logic [31:0] pc4_op
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   pend_pc;
    logic          outstanding;
    logic          discard;

    logic          redirect;
    logic          req;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          unused_target_bits;

    assign unused_target_bits = ^branch_target_ip[1:0];

    assign redirect = flush_en_ip && (pc_mux_ip == ALU_RESULT);
    // Gating on the registered count means a full FIFO never requests, even on a pop cycle.
    assign req      = !reset && !outstanding && (fifo_count < DEPTH_CNT);
    assign grant    = req && imem_gnt_ip;
    assign resp     = imem_rvalid_ip && outstanding;
    assign push     = resp && !discard && !flush_en_ip && !fifo_full;
    assign pop      = !flush_en_ip && !stall_ip && !fifo_empty;

    assign push_entry   = '{instr: imem_rdata_ip, pc: pend_pc};
    assign imem_req_op  = req;
    assign imem_addr_op = pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush_en_ip),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A word still in flight when the path is flushed is marked for discard so it never reaches ID.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= BOOT_ADDR;
            pend_pc     <= BOOT_ADDR;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (flush_en_ip) begin
            if (redirect) pc_q <= {branch_target_ip[31:2], 2'b00};
            if (grant) begin
                outstanding <= 1'b1;
                discard     <= 1'b1;
                pend_pc     <= pc_q;
            end else if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end else begin
                discard     <= outstanding;
            end
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                pend_pc     <= pc_q;
                pc_q        <= pc_q + 32'd4;
            end else if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
        end
    end

    // ID output register; when the FIFO runs dry a bubble is shown but the last PC is kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_data_valid_op <= 1'b0;
            instr_data_op       <= NOP_INSTR;
            pc_op               <= 32'd0;
            pc4_op              <= 32'd4;
        end else if (flush_en_ip) begin
            instr_data_valid_op <= 1'b0;
            instr_data_op       <= NOP_INSTR;
        end else if (!stall_ip) begin
            if (!fifo_empty) begin
                instr_data_valid_op <= 1'b1;
                instr_data_op       <= head.instr;
                pc_op               <= head.pc;
                pc4_op              <= head.pc + 32'd4;
            end else begin
                instr_data_valid_op <= 1'b0;
                instr_data_op       <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-cycle memory/control inputs with
// hand-computed request and ID-output expectations, plus hand sequences around reset.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        stall_ip;
    logic        flush_en_ip;
    pc_mux       pc_mux_ip;
    logic [31:0] branch_target_ip;
    logic        imem_req_op;
    logic [31:0] imem_addr_op;
    logic        imem_gnt_ip;
    logic        imem_rvalid_ip;
    logic [31:0] imem_rdata_ip;
    logic        instr_data_valid_op;
    logic [31:0] instr_data_op;
    logic [31:0] pc_op;
    logic [31:0] pc4_op;

    int checkCount;
    int passCount;

    typedef struct {
        logic        stall;
        logic        flush;
        pc_mux       pcm;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    if_fetch_unit dut (
        .clock               (clock),
        .reset               (reset),
        .stall_ip            (stall_ip),
        .flush_en_ip         (flush_en_ip),
        .pc_mux_ip           (pc_mux_ip),
        .branch_target_ip    (branch_target_ip),
        .imem_req_op         (imem_req_op),
        .imem_addr_op        (imem_addr_op),
        .imem_gnt_ip         (imem_gnt_ip),
        .imem_rvalid_ip      (imem_rvalid_ip),
        .imem_rdata_ip       (imem_rdata_ip),
        .instr_data_valid_op (instr_data_valid_op),
        .instr_data_op       (instr_data_op),
        .pc_op               (pc_op),
        .pc4_op              (pc4_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void v(input logic stall, input logic flush, input pc_mux pcm,
                              input logic [31:0] tgt, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] einstr, input logic [31:0] epc);
        vecs.push_back('{stall, flush, pcm, tgt, gnt, rv, rdata, ereq, eaddr, evalid, einstr, epc});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkId(input string tag, input logic evalid, input logic [31:0] einstr,
                           input logic [31:0] epc);
        checkOutput({tag, " valid"}, 32'(instr_data_valid_op), 32'(evalid));
        checkOutput({tag, " instr"}, instr_data_op, einstr);
        checkOutput({tag, " pc"},    pc_op, epc);
        checkOutput({tag, " pc4"},   pc4_op, epc + 32'd4);
    endtask

    task automatic checkReq(input string tag, input logic ereq, input logic [31:0] eaddr);
        checkOutput({tag, " req"},  32'(imem_req_op), 32'(ereq));
        checkOutput({tag, " addr"}, imem_addr_op, eaddr);
    endtask

    task automatic applyStimulus(input int i);
        string tag;
        tag = $sformatf("row%0d", i);
        @(negedge clock);
        stall_ip         = vecs[i].stall;
        flush_en_ip      = vecs[i].flush;
        pc_mux_ip        = vecs[i].pcm;
        branch_target_ip = vecs[i].tgt;
        imem_gnt_ip      = vecs[i].gnt;
        imem_rvalid_ip   = vecs[i].rv;
        imem_rdata_ip    = vecs[i].rdata;
        #1;
        checkReq(tag, vecs[i].ereq, vecs[i].eaddr);
        @(posedge clock);
        #1;
        checkId(tag, vecs[i].evalid, vecs[i].einstr, vecs[i].epc);
    endtask

    task automatic idleInputs();
        stall_ip         = 1'b0;
        flush_en_ip      = 1'b0;
        pc_mux_ip        = NEXTPC;
        branch_target_ip = 32'd0;
        imem_gnt_ip      = 1'b0;
        imem_rvalid_ip   = 1'b0;
        imem_rdata_ip    = 32'd0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        idleInputs();
        reset = 1'b1;

        //  stall flush pcm         tgt       gnt rv rdata      ereq eaddr     evalid einstr    epc
        // free-running single-cycle memory, 2-cycle cadence
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h000, 0, NOP,     32'h000); // 0
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h0A0, 0, 32'h004, 0, NOP,     32'h000); // 1
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h004, 1, 32'h0A0, 32'h000); // 2
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h0A4, 0, 32'h008, 0, NOP,     32'h000); // 3
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h008, 1, 32'h0A4, 32'h004); // 4
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h0A8, 0, 32'h00C, 0, NOP,     32'h004); // 5
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h00C, 1, 32'h0A8, 32'h008); // 6
        // redirect to 0x100 while 0x0C is outstanding; its rvalid a cycle later is discarded
        v(0, 1, ALU_RESULT, 32'h100, 0, 0, 32'h0,   0, 32'h010, 0, NOP,     32'h008); // 7
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h0AC, 0, 32'h100, 0, NOP,     32'h008); // 8
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h100, 0, NOP,     32'h008); // 9
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h1A0, 0, 32'h104, 0, NOP,     32'h008); // 10
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h104, 1, 32'h1A0, 32'h100); // 11
        // gnt held off 3 cycles, rvalid 4 cycles after gnt
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h104, 0, NOP,     32'h100); // 12
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h104, 0, NOP,     32'h100); // 13
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h104, 0, NOP,     32'h100); // 14
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h104, 0, NOP,     32'h100); // 15
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h108, 0, NOP,     32'h100); // 16
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h108, 0, NOP,     32'h100); // 17
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h108, 0, NOP,     32'h100); // 18
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h1A4, 0, 32'h108, 0, NOP,     32'h100); // 19
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h108, 1, 32'h1A4, 32'h104); // 20
        // stray rvalid with nothing outstanding is ignored
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'hDEAD, 1, 32'h108, 0, NOP,    32'h104); // 21
        // redirect in the same cycle as gnt, unaligned target
        v(0, 1, ALU_RESULT, 32'h203, 1, 0, 32'h0,   1, 32'h108, 0, NOP,     32'h104); // 22
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'hBAD, 0, 32'h200, 0, NOP,     32'h104); // 23
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h200, 0, NOP,     32'h104); // 24
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h2A0, 0, 32'h204, 0, NOP,     32'h104); // 25
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h204, 1, 32'h2A0, 32'h200); // 26
        // redirect in the same cycle as rvalid
        v(0, 1, ALU_RESULT, 32'h303, 0, 1, 32'h2A4, 0, 32'h208, 0, NOP,     32'h200); // 27
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h300, 0, NOP,     32'h200); // 28
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h3A0, 0, 32'h304, 0, NOP,     32'h200); // 29
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h304, 1, 32'h3A0, 32'h300); // 30
        // plain flush: in-flight word dropped, PC not moved
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h304, 0, NOP,     32'h300); // 31
        v(0, 1, NEXTPC,     32'h500, 0, 0, 32'h0,   0, 32'h308, 0, NOP,     32'h300); // 32
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h3A4, 0, 32'h308, 0, NOP,     32'h300); // 33
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h308, 0, NOP,     32'h300); // 34
        // stall for 6 cycles: outputs frozen, FIFO fills, requests stop
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h308, 0, NOP,     32'h300); // 35
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h3A8, 0, 32'h30C, 0, NOP,     32'h300); // 36
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h30C, 1, 32'h3A8, 32'h308); // 37
        v(1, 0, NEXTPC,     32'h0,   0, 1, 32'h3AC, 0, 32'h310, 1, 32'h3A8, 32'h308); // 38
        v(1, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h310, 1, 32'h3A8, 32'h308); // 39
        v(1, 0, NEXTPC,     32'h0,   0, 1, 32'h3B0, 0, 32'h314, 1, 32'h3A8, 32'h308); // 40
        v(1, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h314, 1, 32'h3A8, 32'h308); // 41
        v(1, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h314, 1, 32'h3A8, 32'h308); // 42
        v(1, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h314, 1, 32'h3A8, 32'h308); // 43
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   0, 32'h314, 1, 32'h3AC, 32'h30C); // 44
        v(0, 0, NEXTPC,     32'h0,   1, 0, 32'h0,   1, 32'h314, 1, 32'h3B0, 32'h310); // 45
        v(0, 0, NEXTPC,     32'h0,   0, 1, 32'h3B4, 0, 32'h318, 0, NOP,     32'h310); // 46
        v(0, 0, NEXTPC,     32'h0,   0, 0, 32'h0,   1, 32'h318, 1, 32'h3B4, 32'h314); // 47

        // reset values while reset is held
        #2;
        checkReq("reset", 1'b0, 32'h0);
        checkId("reset", 1'b0, NOP, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

        // reset asserted between edges while a request is outstanding
        @(negedge clock);
        imem_gnt_ip = 1'b1;
        @(posedge clock);
        #1;
        checkReq("pre-reset", 1'b0, 32'h31C);
        imem_gnt_ip = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkReq("async reset", 1'b0, 32'h0);
        checkId("async reset", 1'b0, NOP, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset          = 1'b0;
        imem_rvalid_ip = 1'b1;
        imem_rdata_ip  = 32'hDEAD;
        #1;
        checkReq("late rvalid", 1'b1, 32'h0);
        @(negedge clock);
        imem_rvalid_ip = 1'b0;
        imem_gnt_ip    = 1'b1;
        @(posedge clock);
        #1;
        checkId("after late rvalid", 1'b0, NOP, 32'h0);
        checkReq("restart", 1'b0, 32'h4);
        @(negedge clock);
        imem_gnt_ip    = 1'b0;
        imem_rvalid_ip = 1'b1;
        imem_rdata_ip  = 32'h0A0;
        @(negedge clock);
        imem_rvalid_ip = 1'b0;
        @(posedge clock);
        #1;
        checkId("restart", 1'b1, 32'h0A0, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
